mips_mc_ctrl: RTL

Multi-cycle main controller for the MIPS datapath. It decodes opcode/funct and sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the select inputs of the datapath muxes (RegDst, ALUSrc, MemtoReg) and all write enables. It waits on a data-memory ready handshake with a bounded timeout.

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/mips_mc_decode.sv | 55 +++++
 rtl/mips_mc_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode, funct, ALU, PC-mux and controller state constants
//
// Purpose : single source of encodings for the multi-cycle controller, the
//           datapath ALU and the PC mux.
// Ports   : none (package).

package mips_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  // PC source mux select
  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  // Controller states (4-bit, codes 12..15 are unreachable)
  localparam logic [3:0] S_IF      = 4'd0;
  localparam logic [3:0] S_ID      = 4'd1;
  localparam logic [3:0] S_EX_R    = 4'd2;
  localparam logic [3:0] S_EX_I    = 4'd3;
  localparam logic [3:0] S_EX_ADDR = 4'd4;
  localparam logic [3:0] S_EX_BEQ  = 4'd5;
  localparam logic [3:0] S_JUMP    = 4'd6;
  localparam logic [3:0] S_MEM_RD  = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_WB_R    = 4'd9;
  localparam logic [3:0] S_WB_I    = 4'd10;
  localparam logic [3:0] S_WB_LW   = 4'd11;

  // Instruction class produced by the decoder
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_ORI = 3'd1,
    CLS_LUI = 3'd2,
    CLS_LW  = 3'd3,
    CLS_SW  = 3'd4,
    CLS_BEQ = 3'd5,
    CLS_J   = 3'd6,
    CLS_ILL = 3'd7
  } instr_cls_e;

  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// rtl/mips_mc_decode.sv - combinational opcode/funct decoder for the multi-cycle controller
//
// Purpose : classify an instruction and pick its ALU operation.
// Ports   : i_op[5:0]       instr[31:26]
//           i_funct[5:0]    instr[5:0]
//           o_cls           instruction class (CLS_ILL when undecodable)
//           o_alu_ctrl[2:0] ALU operation for the class/funct
//           o_illegal       1 when op, or funct of an R-type, is unsupported

module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output instr_cls_e o_cls,
  output logic [2:0] o_alu_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_cls      = CLS_ILL;
    o_alu_ctrl = ALU_ADD;
    case (i_op)
      OP_RTYPE: begin
        o_cls = CLS_R;
        case (i_funct)
          FN_ADDU: o_alu_ctrl = ALU_ADD;
          FN_SUBU: o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_cls      = CLS_ILL;
        endcase
      end
      OP_ORI: begin
        o_cls      = CLS_ORI;
        o_alu_ctrl = ALU_OR;
      end
      OP_LUI: begin
        o_cls      = CLS_LUI;
        o_alu_ctrl = ALU_LUI;
      end
      OP_LW:  o_cls = CLS_LW;
      OP_SW:  o_cls = CLS_SW;
      OP_BEQ: begin
        o_cls      = CLS_BEQ;
        o_alu_ctrl = ALU_SUB;
      end
      OP_J:    o_cls = CLS_J;
      default: o_cls = CLS_ILL;
    endcase
    o_illegal = (o_cls == CLS_ILL);
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS main controller FSM with bounded memory wait
//
// Purpose : sequence each instruction IF -> ID -> EX -> MEM -> WB and drive
//           datapath mux selects and write enables.
// Ports   : clk, rst_n              clock, synchronous active-low reset
//           op, funct               instruction fields, sampled in S_ID
//           zero                    ALU zero flag (used in S_EX_BEQ)
//           mem_ready               data memory done handshake
//           pc_write, pc_src        PC load enable and source select
//           ir_write, reg_write     IR load, register file write enable
//           mem_read, mem_write     data memory requests
//           reg_dst, alu_src, mem_to_reg, ext_op, alu_ctrl   datapath selects
//           illegal, bus_err        one-cycle error pulses
//           state                   current FSM state (debug)

module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       ext_op,
  output logic [2:0] alu_ctrl,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [5:0] r_op;
  logic [5:0] r_funct;
  logic [7:0] r_wait_cnt;

  logic       w_in_id;
  logic       w_in_mem;
  logic       w_wait_last;
  logic       w_timeout;
  logic       w_sel_active;
  logic [5:0] w_dec_op;
  logic [5:0] w_dec_funct;
  instr_cls_e w_cls;
  logic [2:0] w_dec_alu;
  logic       w_dec_illegal;

  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_dst;
  logic       w_alu_src;
  logic       w_mem_to_reg;
  logic       w_ext_op;
  logic [2:0] w_alu_ctrl;

  assign w_in_id  = (r_state == S_ID);
  assign w_in_mem = is_mem_state(r_state);

  // In S_ID the live instruction fields are decoded (they are being latched
  // on this edge); every later state decodes the latched copy so the
  // selects stay stable regardless of what the instruction bus does.
  assign w_dec_op    = w_in_id ? op    : r_op;
  assign w_dec_funct = w_in_id ? funct : r_funct;

  mips_mc_decode u_decode (
    .i_op       (w_dec_op),
    .i_funct    (w_dec_funct),
    .o_cls      (w_cls),
    .o_alu_ctrl (w_dec_alu),
    .o_illegal  (w_dec_illegal)
  );

  // The counter holds the number of memory cycles already spent, so the
  // current cycle is the WAIT_MAX-th one when it equals WAIT_MAX-1.
  assign w_wait_last = (r_wait_cnt == 8'(WAIT_MAX - 1));
  // A ready arriving on the final allowed cycle wins over the timeout.
  assign w_timeout   = w_in_mem && !mem_ready && w_wait_last;

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF: w_next = S_ID;
      S_ID: begin
        case (w_cls)
          CLS_R:           w_next = S_EX_R;
          CLS_ORI, CLS_LUI: w_next = S_EX_I;
          CLS_LW, CLS_SW:  w_next = S_EX_ADDR;
          CLS_BEQ:         w_next = S_EX_BEQ;
          CLS_J:           w_next = S_JUMP;
          default:         w_next = S_IF;
        endcase
      end
      S_EX_R:    w_next = S_WB_R;
      S_EX_I:    w_next = S_WB_I;
      S_EX_ADDR: w_next = (w_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_EX_BEQ:  w_next = S_IF;
      S_JUMP:    w_next = S_IF;
      S_MEM_RD: begin
        if (mem_ready)        w_next = S_WB_LW;
        else if (w_wait_last) w_next = S_IF;
        else                  w_next = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready || w_wait_last) w_next = S_IF;
        else                          w_next = S_MEM_WR;
      end
      S_WB_R:  w_next = S_IF;
      S_WB_I:  w_next = S_IF;
      S_WB_LW: w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IF;
      r_wait_cnt <= 8'd0;
      r_op       <= 6'd0;
      r_funct    <= 6'd0;
    end else begin
      r_state <= w_next;
      if (w_in_id) begin
        r_op    <= op;
        r_funct <= funct;
      end
      if (w_in_mem && !mem_ready && !w_wait_last)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      else
        r_wait_cnt <= 8'd0;
    end
  end

  // Datapath selects are driven from the first EX state through write-back
  // and derived from the instruction class, so they cannot glitch between
  // the EX, MEM and WB states of one instruction.
  assign w_sel_active = (r_state >= S_EX_R) && (r_state <= S_WB_LW);

  always_comb begin
    w_pc_write   = 1'b0;
    w_pc_src     = PC_SRC_SEQ;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_ext_op     = 1'b0;
    w_alu_ctrl   = ALU_ADD;

    if (w_sel_active) begin
      w_reg_dst    = (w_cls == CLS_R);
      w_alu_src    = (w_cls == CLS_ORI) || (w_cls == CLS_LUI) ||
                     (w_cls == CLS_LW)  || (w_cls == CLS_SW);
      w_mem_to_reg = (w_cls == CLS_LW);
      w_ext_op     = (w_cls == CLS_LW) || (w_cls == CLS_SW) || (w_cls == CLS_BEQ);
      w_alu_ctrl   = w_dec_alu;
    end

    case (r_state)
      S_IF: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        w_pc_src   = PC_SRC_SEQ;
      end
      S_EX_BEQ: begin
        w_pc_src   = PC_SRC_BR;
        w_pc_write = zero;
      end
      S_JUMP: begin
        w_pc_src   = PC_SRC_JMP;
        w_pc_write = 1'b1;
      end
      S_MEM_RD: w_mem_read  = 1'b1;
      S_MEM_WR: w_mem_write = 1'b1;
      S_WB_R, S_WB_I, S_WB_LW: w_reg_write = 1'b1;
      default: ;
    endcase
  end

  // Reset forces every output low combinationally so an instruction caught
  // mid-flight cannot write on the reset edge.
  assign pc_write   = rst_n & w_pc_write;
  assign pc_src     = rst_n ? w_pc_src : 2'b00;
  assign ir_write   = rst_n & w_ir_write;
  assign reg_write  = rst_n & w_reg_write;
  assign mem_read   = rst_n & w_mem_read;
  assign mem_write  = rst_n & w_mem_write;
  assign reg_dst    = rst_n & w_reg_dst;
  assign alu_src    = rst_n & w_alu_src;
  assign mem_to_reg = rst_n & w_mem_to_reg;
  assign ext_op     = rst_n & w_ext_op;
  assign alu_ctrl   = rst_n ? w_alu_ctrl : 3'b000;
  assign illegal    = rst_n & w_in_id & w_dec_illegal;
  assign bus_err    = rst_n & w_timeout;
  assign state      = rst_n ? r_state : 4'd0;

endmodule
